// File: rtl/ras_ckpt_pkg.sv
// Shared types and constants for the checkpointed return address stack.
// The decode-stage checker imports this package as well.
package ras_ckpt_pkg;

  localparam int RAS_DEPTH = 16;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    BOTH = 2'd3
  } ras_op_e;

  function automatic logic is_link(input logic [4:0] reg_addr);
    return (reg_addr == LINK_X1) || (reg_addr == LINK_X5);
  endfunction

endpackage

// File: rtl/ras_ckpt_if.sv
// Fetch-stage request, prediction and checkpoint bundle for the RAS.
// The master side is the predictor front-end; the slave side is the stack.
interface ras_ckpt_if
  import ras_ckpt_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int XLEN  = 32
) ();

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int CKPT_W = PTR_W + CNT_W + XLEN;

  logic              req_valid_i;
  logic              j_type_i;
  logic              jr_type_i;
  logic [4:0]        rd_addr_i;
  logic [4:0]        r1_addr_i;
  logic [XLEN-1:0]   return_addr_i;
  logic              restore_i;
  logic [CKPT_W-1:0] restore_ckpt_i;
  logic [XLEN-1:0]   popped_addr_o;
  logic              predict_valid_o;
  logic [CKPT_W-1:0] ckpt_o;

  modport master (
    output req_valid_i, j_type_i, jr_type_i, rd_addr_i, r1_addr_i,
           return_addr_i, restore_i, restore_ckpt_i,
    input  popped_addr_o, predict_valid_o, ckpt_o
  );

  modport slave (
    input  req_valid_i, j_type_i, jr_type_i, rd_addr_i, r1_addr_i,
           return_addr_i, restore_i, restore_ckpt_i,
    output popped_addr_o, predict_valid_o, ckpt_o
  );

endinterface

// File: rtl/ras_ckpt_op_decode.sv
// Classifies a decoded control-flow instruction into a RAS operation
// using the x1/x5 link-register hint rules.
module ras_op_decode
  import ras_ckpt_pkg::*;
(
  input  logic       req_valid,
  input  logic       j_type,
  input  logic       jr_type,
  input  logic [4:0] rd_addr,
  input  logic [4:0] r1_addr,
  output ras_op_e    op
);

  logic rd_link;
  logic r1_link;

  assign rd_link = is_link(rd_addr);
  assign r1_link = is_link(r1_addr);

  // Coroutine-style jalr with two distinct link registers pops and pushes at once.
  always_comb begin
    op = NONE;
    if (req_valid) begin
      if (j_type) begin
        if (rd_link) op = PUSH;
      end else if (jr_type) begin
        case ({rd_link, r1_link})
          2'b10:   op = PUSH;
          2'b01:   op = POP;
          2'b11:   op = (rd_addr == r1_addr) ? PUSH : BOTH;
          default: op = NONE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ras_ckpt.sv
// Circular-buffer return address stack with a flat {tos, count, top}
// checkpoint for exact recovery on flush, plus saturating overflow/underflow counters.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter  int DEPTH  = RAS_DEPTH,
  parameter  int XLEN   = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int CKPT_W = PTR_W + CNT_W + XLEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ras_ckpt_if.slave        bus,
  output logic [CNT_W-1:0] count_o,
  output logic [15:0]      overflow_cnt_o,
  output logic [15:0]      underflow_cnt_o
);

  localparam int CKPT_TOP_LSB = 0;
  localparam int CKPT_CNT_LSB = XLEN;
  localparam int CKPT_TOS_LSB = XLEN + CNT_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  ras_op_e op;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] tos_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [XLEN-1:0]  mem_wdata;
  logic             ovf_inc;
  logic             unf_inc;

  logic [PTR_W-1:0] ckpt_tos;
  logic [CNT_W-1:0] ckpt_cnt;
  logic [XLEN-1:0]  ckpt_top;

  ras_op_decode u_op_decode (
    .req_valid (bus.req_valid_i),
    .j_type    (bus.j_type_i),
    .jr_type   (bus.jr_type_i),
    .rd_addr   (bus.rd_addr_i),
    .r1_addr   (bus.r1_addr_i),
    .op        (op)
  );

  assign ckpt_tos = bus.restore_ckpt_i[CKPT_TOS_LSB +: PTR_W];
  assign ckpt_cnt = bus.restore_ckpt_i[CKPT_CNT_LSB +: CNT_W];
  assign ckpt_top = bus.restore_ckpt_i[CKPT_TOP_LSB +: XLEN];

  assign bus.popped_addr_o   = mem[tos];
  assign bus.ckpt_o          = {tos, count, mem[tos]};
  assign bus.predict_valid_o = bus.req_valid_i && ((op == POP) || (op == BOTH)) &&
                               (count != '0) && !bus.restore_i;
  assign count_o             = count;

  // A flush overrides the request entirely, including its counter side effects.
  always_comb begin
    tos_nxt   = tos;
    count_nxt = count;
    mem_we    = 1'b0;
    mem_waddr = tos;
    mem_wdata = bus.return_addr_i;
    ovf_inc   = 1'b0;
    unf_inc   = 1'b0;
    if (bus.restore_i) begin
      tos_nxt   = ckpt_tos;
      count_nxt = ckpt_cnt;
      mem_we    = 1'b1;
      mem_waddr = ckpt_tos;
      mem_wdata = ckpt_top;
    end else begin
      case (op)
        PUSH: begin
          tos_nxt   = tos + PTR_W'(1);
          mem_we    = 1'b1;
          mem_waddr = tos + PTR_W'(1);
          if (count == CNT_FULL) ovf_inc   = 1'b1;
          else                   count_nxt = count + CNT_W'(1);
        end
        POP: begin
          if (count != '0) begin
            tos_nxt   = tos - PTR_W'(1);
            count_nxt = count - CNT_W'(1);
          end else begin
            unf_inc = 1'b1;
          end
        end
        BOTH: begin
          mem_we = 1'b1;
          if (count == '0) begin
            count_nxt = CNT_W'(1);
            unf_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tos   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      tos   <= tos_nxt;
      count <= count_nxt;
      if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_cnt_o  <= '0;
      underflow_cnt_o <= '0;
    end else begin
      if (ovf_inc && (overflow_cnt_o != 16'hFFFF))
        overflow_cnt_o <= overflow_cnt_o + 16'd1;
      if (unf_inc && (underflow_cnt_o != 16'hFFFF))
        underflow_cnt_o <= underflow_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: push/pop, overflow wrap, BOTH, checkpoint
// restore, restore priority, decode classes and asynchronous reset.
module tb_ras_ckpt;

  localparam int DEPTH  = 16;
  localparam int XLEN   = 32;
  localparam int CNT_W  = 5;
  localparam int CKPT_W = 41;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [CNT_W-1:0] count_o;
  logic [15:0]      overflow_cnt_o;
  logic [15:0]      underflow_cnt_o;

  int vectors    = 0;
  int miscompares = 0;

  ras_ckpt_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  ras_ckpt #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .bus             (bus),
    .count_o         (count_o),
    .overflow_cnt_o  (overflow_cnt_o),
    .underflow_cnt_o (underflow_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic j, input logic jr,
                       input logic [4:0] rd, input logic [4:0] r1,
                       input logic [XLEN-1:0] ra);
    bus.req_valid_i   = v;
    bus.j_type_i      = j;
    bus.jr_type_i     = jr;
    bus.rd_addr_i     = rd;
    bus.r1_addr_i     = r1;
    bus.return_addr_i = ra;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, '0);
  endtask

  task automatic drive_push(input logic [XLEN-1:0] ra);
    drive(1'b1, 1'b1, 1'b0, 5'd1, 5'd0, ra);
  endtask

  task automatic drive_pop();
    drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd1, '0);
  endtask

  task automatic push_cycle(input logic [XLEN-1:0] ra);
    drive_push(ra);
    step();
    drive_idle();
  endtask

  task automatic do_reset();
    bus.restore_i      = 1'b0;
    bus.restore_ckpt_i = '0;
    drive_idle();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.popped_addr_o !== 32'h0) begin $display("[TB] FAIL reset_popped got %h want 0", bus.popped_addr_o); miscompares++; end
    vectors++; if (count_o !== 5'd0) begin $display("[TB] FAIL reset_count got %0d want 0", count_o); miscompares++; end
    vectors++; if (bus.ckpt_o !== 41'h0) begin $display("[TB] FAIL reset_ckpt got %h want 0", bus.ckpt_o); miscompares++; end
    vectors++; if (overflow_cnt_o !== 16'h0 || underflow_cnt_o !== 16'h0) begin $display("[TB] FAIL reset_evcnt got %h/%h want 0/0", overflow_cnt_o, underflow_cnt_o); miscompares++; end
    drive_pop();
    vectors++; if (bus.predict_valid_o !== 1'b0) begin $display("[TB] FAIL reset_predict got %b want 0", bus.predict_valid_o); miscompares++; end
    drive_idle();
  endtask

  task automatic test_push_pop();
    do_reset();
    push_cycle(32'h100);
    push_cycle(32'h200);
    push_cycle(32'h300);
    vectors++; if (count_o !== 5'd3) begin $display("[TB] FAIL pp_count got %0d want 3", count_o); miscompares++; end
    vectors++; if (bus.popped_addr_o !== 32'h300) begin $display("[TB] FAIL pp_top got %h want 300", bus.popped_addr_o); miscompares++; end
    drive_pop();
    vectors++; if (bus.predict_valid_o !== 1'b1 || bus.popped_addr_o !== 32'h300) begin $display("[TB] FAIL pp_pop got v=%b %h want v=1 300", bus.predict_valid_o, bus.popped_addr_o); miscompares++; end
    step();
    drive_idle();
    vectors++; if (bus.popped_addr_o !== 32'h200 || count_o !== 5'd2) begin $display("[TB] FAIL pp_after got %h cnt %0d want 200 cnt 2", bus.popped_addr_o, count_o); miscompares++; end
  endtask

  task automatic test_overflow();
    logic [XLEN-1:0] exp_addr;
    do_reset();
    for (int i = 0; i < 16; i++) push_cycle(32'h1000 + 32'(4 * i));
    vectors++; if (count_o !== 5'd16 || overflow_cnt_o !== 16'd0) begin $display("[TB] FAIL ovf_full got cnt %0d ovf %0d want 16 0", count_o, overflow_cnt_o); miscompares++; end
    push_cycle(32'h1040);
    vectors++; if (count_o !== 5'd16 || overflow_cnt_o !== 16'd1) begin $display("[TB] FAIL ovf_wrap got cnt %0d ovf %0d want 16 1", count_o, overflow_cnt_o); miscompares++; end
    for (int k = 0; k < 16; k++) begin
      exp_addr = 32'h1040 - 32'(4 * k);
      drive_pop();
      vectors++; if (bus.predict_valid_o !== 1'b1 || bus.popped_addr_o !== exp_addr) begin $display("[TB] FAIL ovf_pop%0d got v=%b %h want v=1 %h", k, bus.predict_valid_o, bus.popped_addr_o, exp_addr); miscompares++; end
      step();
    end
    drive_pop();
    vectors++; if (bus.predict_valid_o !== 1'b0) begin $display("[TB] FAIL unf_predict got %b want 0", bus.predict_valid_o); miscompares++; end
    step();
    drive_idle();
    vectors++; if (underflow_cnt_o !== 16'd1 || count_o !== 5'd0) begin $display("[TB] FAIL unf_cnt got unf %0d cnt %0d want 1 0", underflow_cnt_o, count_o); miscompares++; end
  endtask

  task automatic test_both();
    do_reset();
    push_cycle(32'hA0);
    drive(1'b1, 1'b0, 1'b1, 5'd1, 5'd5, 32'hB4);
    vectors++; if (bus.predict_valid_o !== 1'b1 || bus.popped_addr_o !== 32'hA0) begin $display("[TB] FAIL both_pred got v=%b %h want v=1 a0", bus.predict_valid_o, bus.popped_addr_o); miscompares++; end
    step();
    drive_idle();
    vectors++; if (bus.popped_addr_o !== 32'hB4 || count_o !== 5'd1) begin $display("[TB] FAIL both_after got %h cnt %0d want b4 cnt 1", bus.popped_addr_o, count_o); miscompares++; end
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 32'h44);
    vectors++; if (bus.predict_valid_o !== 1'b0) begin $display("[TB] FAIL both_empty_pred got %b want 0", bus.predict_valid_o); miscompares++; end
    step();
    drive_idle();
    vectors++; if (bus.popped_addr_o !== 32'h44 || count_o !== 5'd1 || underflow_cnt_o !== 16'd1) begin $display("[TB] FAIL both_empty got %h cnt %0d unf %0d want 44 1 1", bus.popped_addr_o, count_o, underflow_cnt_o); miscompares++; end
  endtask

  task automatic test_restore();
    logic [CKPT_W-1:0] saved;
    do_reset();
    push_cycle(32'h100);
    push_cycle(32'h200);
    push_cycle(32'h300);
    drive_pop();
    saved = bus.ckpt_o;
    vectors++; if (saved !== {4'd3, 5'd3, 32'h300}) begin $display("[TB] FAIL ckpt_value got %h want %h", saved, {4'd3, 5'd3, 32'h300}); miscompares++; end
    step();
    push_cycle(32'h900);
    vectors++; if (bus.popped_addr_o !== 32'h900) begin $display("[TB] FAIL rst_pre got %h want 900", bus.popped_addr_o); miscompares++; end
    bus.restore_i      = 1'b1;
    bus.restore_ckpt_i = saved;
    step();
    bus.restore_i = 1'b0;
    #1;
    vectors++; if (bus.popped_addr_o !== 32'h300 || count_o !== 5'd3) begin $display("[TB] FAIL restore got %h cnt %0d want 300 cnt 3", bus.popped_addr_o, count_o); miscompares++; end
    drive_pop();
    vectors++; if (bus.predict_valid_o !== 1'b1 || bus.popped_addr_o !== 32'h300) begin $display("[TB] FAIL restore_pop got v=%b %h want v=1 300", bus.predict_valid_o, bus.popped_addr_o); miscompares++; end
    step();
    drive_idle();
    vectors++; if (bus.popped_addr_o !== 32'h200) begin $display("[TB] FAIL restore_below got %h want 200", bus.popped_addr_o); miscompares++; end
  endtask

  task automatic test_restore_priority();
    do_reset();
    push_cycle(32'h10);
    bus.restore_i      = 1'b1;
    bus.restore_ckpt_i = {4'd1, 5'd1, 32'h10};
    drive_push(32'h20);
    vectors++; if (bus.predict_valid_o !== 1'b0) begin $display("[TB] FAIL prio_push_pred got %b want 0", bus.predict_valid_o); miscompares++; end
    step();
    vectors++; if (bus.popped_addr_o !== 32'h10 || count_o !== 5'd1) begin $display("[TB] FAIL prio_push got %h cnt %0d want 10 cnt 1", bus.popped_addr_o, count_o); miscompares++; end
    drive_pop();
    vectors++; if (bus.predict_valid_o !== 1'b0) begin $display("[TB] FAIL prio_pop_pred got %b want 0", bus.predict_valid_o); miscompares++; end
    step();
    vectors++; if (count_o !== 5'd1 || bus.popped_addr_o !== 32'h10) begin $display("[TB] FAIL prio_pop got %h cnt %0d want 10 cnt 1", bus.popped_addr_o, count_o); miscompares++; end
    bus.restore_ckpt_i = '0;
    drive_pop();
    step();
    bus.restore_i = 1'b0;
    drive_idle();
    vectors++; if (underflow_cnt_o !== 16'd0 || overflow_cnt_o !== 16'd0 || count_o !== 5'd0) begin $display("[TB] FAIL prio_evcnt got unf %0d ovf %0d cnt %0d want 0 0 0", underflow_cnt_o, overflow_cnt_o, count_o); miscompares++; end
  endtask

  task automatic test_decode();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd6, 32'h50);
    step();
    vectors++; if (count_o !== 5'd1 || bus.popped_addr_o !== 32'h50) begin $display("[TB] FAIL dec_jr_rd got %h cnt %0d want 50 cnt 1", bus.popped_addr_o, count_o); miscompares++; end
    drive(1'b1, 1'b0, 1'b1, 5'd1, 5'd1, 32'h60);
    step();
    vectors++; if (count_o !== 5'd2 || bus.popped_addr_o !== 32'h60) begin $display("[TB] FAIL dec_jr_same got %h cnt %0d want 60 cnt 2", bus.popped_addr_o, count_o); miscompares++; end
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h70);
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 32'h74);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd6, 32'h78);
    vectors++; if (bus.predict_valid_o !== 1'b0) begin $display("[TB] FAIL dec_none_pred got %b want 0", bus.predict_valid_o); miscompares++; end
    step();
    vectors++; if (count_o !== 5'd2 || bus.popped_addr_o !== 32'h60) begin $display("[TB] FAIL dec_none got %h cnt %0d want 60 cnt 2", bus.popped_addr_o, count_o); miscompares++; end
    drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 32'h0);
    vectors++; if (bus.predict_valid_o !== 1'b1 || bus.popped_addr_o !== 32'h60) begin $display("[TB] FAIL dec_pop_x5 got v=%b %h want v=1 60", bus.predict_valid_o, bus.popped_addr_o); miscompares++; end
    step();
    drive_idle();
    vectors++; if (count_o !== 5'd1 || bus.popped_addr_o !== 32'h50) begin $display("[TB] FAIL dec_after got %h cnt %0d want 50 cnt 1", bus.popped_addr_o, count_o); miscompares++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) push_cycle(32'h500 + 32'(i));
    vectors++; if (count_o !== 5'd5) begin $display("[TB] FAIL ar_pre got cnt %0d want 5", count_o); miscompares++; end
    drive_push(32'h999);
    #1;
    rst_i = 1'b1;
    #1;
    vectors++; if (bus.popped_addr_o !== 32'h0 || count_o !== 5'd0 || bus.ckpt_o !== 41'h0 || bus.predict_valid_o !== 1'b0) begin $display("[TB] FAIL ar_immediate got %h cnt %0d ckpt %h v=%b want all 0", bus.popped_addr_o, count_o, bus.ckpt_o, bus.predict_valid_o); miscompares++; end
    step();
    rst_i = 1'b0;
    drive_pop();
    vectors++; if (bus.predict_valid_o !== 1'b0) begin $display("[TB] FAIL ar_pop_pred got %b want 0", bus.predict_valid_o); miscompares++; end
    step();
    drive_idle();
    vectors++; if (underflow_cnt_o !== 16'd1 || count_o !== 5'd0 || bus.popped_addr_o !== 32'h0) begin $display("[TB] FAIL ar_after got unf %0d cnt %0d top %h want 1 0 0", underflow_cnt_o, count_o, bus.popped_addr_o); miscompares++; end
  endtask

  initial begin
    bus.restore_i      = 1'b0;
    bus.restore_ckpt_i = '0;
    bus.req_valid_i    = 1'b0;
    bus.j_type_i       = 1'b0;
    bus.jr_type_i      = 1'b0;
    bus.rd_addr_i      = '0;
    bus.r1_addr_i      = '0;
    bus.return_addr_i  = '0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_both();
    test_restore();
    test_restore_priority();
    test_decode();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
